// File: rtl/cnt_stream_rx.sv
// Receive-side checker for the count-transaction stream: parity, +1 sequencing, period and reset-window legality.
// Define CNT_STREAM_RX_PERIOD_CHECK_EN to build the valid-to-valid period checker; otherwise err_period is tied to 0.
module cnt_stream_rx #(
    parameter int MIN_PERIOD = 8,
    parameter int MAX_PERIOD = 13,
    parameter int RST_WIN    = 44
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] count_in,
    input  logic        parity_in,
    input  logic        valid_in,
    input  logic        rst_req,
    output logic [31:0] last_count,
    output logic [31:0] txn_cnt,
    output logic [15:0] err_cnt,
    output logic        err_parity,
    output logic        err_seq,
    output logic        err_period,
    output logic        err_window,
    output logic        in_window
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TRACK   = 2'd1;
    localparam logic [1:0] S_WINDOW  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam int              TW       = $clog2(RST_WIN + 1);
    localparam logic [TW-1:0]   WIN_LOAD = TW'(RST_WIN);

    if (MIN_PERIOD < 1 || MIN_PERIOD > MAX_PERIOD || MAX_PERIOD > 255 || RST_WIN < 1) begin : g_bad_cfg
        $error("cnt_stream_rx: inconsistent period/window parameters");
    end

    function automatic logic [15:0] sat_add_err(input logic [15:0] cnt, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {14'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [1:0]    state_q, state_d, eff_state;
    logic [TW-1:0] timer_q, timer_d;
    logic          rst_req_q, rst_req_d;
    logic [31:0]   last_count_q, last_count_d;
    logic [31:0]   txn_cnt_q, txn_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          err_parity_q, err_parity_d;
    logic          err_seq_q, err_seq_d;
    logic          err_period_q, err_period_d;
    logic          err_window_q, err_window_d;
    logic          win_rise;
`ifdef CNT_STREAM_RX_PERIOD_CHECK_EN
    localparam logic [7:0] MIN_P8 = 8'(MIN_PERIOD);
    localparam logic [7:0] MAX_P8 = 8'(MAX_PERIOD);
    logic [7:0]    per_q, per_d;
`endif

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rst_req_d    = rst_req;
        last_count_d = last_count_q;
        txn_cnt_d    = txn_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_parity_d = 1'b0;
        err_seq_d    = 1'b0;
        err_period_d = 1'b0;
        err_window_d = 1'b0;

        // A request edge outside IDLE makes a coincident transaction subject to window rules.
        win_rise  = rst_req && !rst_req_q && (state_q != S_IDLE);
        eff_state = win_rise ? S_WINDOW : state_q;

        if (state_q == S_WINDOW) begin
            if (timer_q != '0) timer_d = timer_q - TW'(1);
            if (timer_q <= TW'(1)) state_d = S_EXPIRED;
        end

`ifdef CNT_STREAM_RX_PERIOD_CHECK_EN
        per_d = (per_q == 8'hFF) ? per_q : per_q + 8'd1;
`endif

        if (valid_in) begin
            txn_cnt_d    = txn_cnt_q + 32'd1;
            last_count_d = count_in;
            err_parity_d = (parity_in != ^count_in);
            case (eff_state)
                S_IDLE:  state_d = S_TRACK;
                S_TRACK: err_seq_d = (count_in != last_count_q + 32'd1);
                S_WINDOW: begin
                    // A held value keeps the window open; anything else closes it.
                    if (count_in != last_count_q) begin
                        err_window_d = (count_in != 32'd1);
                        state_d      = S_TRACK;
                    end
                end
                default: begin
                    err_window_d = (count_in != 32'd1);
                    state_d      = S_TRACK;
                end
            endcase
`ifdef CNT_STREAM_RX_PERIOD_CHECK_EN
            err_period_d = (state_q != S_IDLE) && (per_q < MIN_P8 || per_q > MAX_P8);
            per_d        = 8'd1;
`endif
            err_cnt_d = sat_add_err(err_cnt_q, {2'd0, err_parity_d} + {2'd0, err_seq_d}
                                             + {2'd0, err_period_d} + {2'd0, err_window_d});
        end

        if (win_rise) begin
            state_d = S_WINDOW;
            timer_d = WIN_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            rst_req_q    <= 1'b0;
            last_count_q <= '0;
            txn_cnt_q    <= '0;
            err_cnt_q    <= '0;
            err_parity_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_period_q <= 1'b0;
            err_window_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rst_req_q    <= rst_req_d;
            last_count_q <= last_count_d;
            txn_cnt_q    <= txn_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_parity_q <= err_parity_d;
            err_seq_q    <= err_seq_d;
            err_period_q <= err_period_d;
            err_window_q <= err_window_d;
        end
    end

`ifdef CNT_STREAM_RX_PERIOD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) per_q <= '0;
        else        per_q <= per_d;
    end
`endif

    assign last_count = last_count_q;
    assign txn_cnt    = txn_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_parity = err_parity_q;
    assign err_seq    = err_seq_q;
    assign err_period = err_period_q;
    assign err_window = err_window_q;
    assign in_window  = (state_q == S_WINDOW);
endmodule

// File: tb/tb_cnt_stream_rx.sv
// Directed bench for cnt_stream_rx; expectations follow whether CNT_STREAM_RX_PERIOD_CHECK_EN is defined.
module tb_cnt_stream_rx;
`ifdef CNT_STREAM_RX_PERIOD_CHECK_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] count_in = '0;
    logic        parity_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        rst_req = 1'b0;
    logic [31:0] last_count, txn_cnt;
    logic [15:0] err_cnt;
    logic        err_parity, err_seq, err_period, err_window, in_window;
    logic [3:0]  errs;
    int          passed = 0;
    int          total = 0;

    assign errs = {err_parity, err_seq, err_period, err_window};

    cnt_stream_rx dut (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .parity_in(parity_in),
        .valid_in(valid_in), .rst_req(rst_req), .last_count(last_count),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt), .err_parity(err_parity),
        .err_seq(err_seq), .err_period(err_period), .err_window(err_window),
        .in_window(in_window)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        valid_in = 1'b0;
        rst_req  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one transaction whose valid sample lies 'period' cycles after the previous one;
    // returns on the negedge where its registered results are visible.
    task automatic txn(input logic [31:0] c, input bit flip, input int period);
        if (period > 2) repeat (period - 2) @(negedge clk);
        @(negedge clk);
        count_in  = c;
        parity_in = (^c) ^ flip;
        valid_in  = 1'b1;
        @(negedge clk);
        valid_in  = 1'b0;
    endtask

    task automatic pulse_rst_req();
        @(negedge clk);
        rst_req = 1'b1;
        @(negedge clk);
        rst_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (txn_cnt !== 32'd0) $display("FAIL reset_txn_cnt: got %0d want 0", txn_cnt); else passed++;
        total++; if (last_count !== 32'd0) $display("FAIL reset_last_count: got %h want 0", last_count); else passed++;
        total++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else passed++;
        total++; if ({errs, in_window} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {errs, in_window}); else passed++;
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        txn(32'd5, 1'b0, 10);
        total++; if (errs !== 4'b0) $display("FAIL basic_5_errs: got %b want 0000", errs); else passed++;
        txn(32'd6, 1'b0, 10);
        total++; if (errs !== 4'b0) $display("FAIL basic_6_errs: got %b want 0000", errs); else passed++;
        txn(32'd7, 1'b0, 10);
        total++; if (errs !== 4'b0) $display("FAIL basic_7_errs: got %b want 0000", errs); else passed++;
        total++; if (txn_cnt !== 32'd3) $display("FAIL basic_txn_cnt: got %0d want 3", txn_cnt); else passed++;
        total++; if (last_count !== 32'd7) $display("FAIL basic_last_count: got %0d want 7", last_count); else passed++;
        total++; if (err_cnt !== 16'd0) $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); else passed++;
    endtask

    task automatic test_parity();
        txn(32'd8, 1'b1, 10);
        total++; if (errs !== 4'b1000) $display("FAIL parity_errs: got %b want 1000", errs); else passed++;
        total++; if (err_cnt !== 16'd1) $display("FAIL parity_err_cnt: got %0d want 1", err_cnt); else passed++;
        total++; if (last_count !== 32'd8) $display("FAIL parity_last_count: got %0d want 8", last_count); else passed++;
        @(negedge clk);
        total++; if (err_parity !== 1'b0) $display("FAIL parity_pulse_width: got %b want 0", err_parity); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        txn(32'hFFFF_FFFE, 1'b0, 10);
        txn(32'hFFFF_FFFF, 1'b0, 10);
        total++; if (errs !== 4'b0) $display("FAIL wrap_ff_errs: got %b want 0000", errs); else passed++;
        txn(32'h0, 1'b0, 10);
        total++; if (errs !== 4'b0) $display("FAIL wrap_zero_errs: got %b want 0000", errs); else passed++;
        txn(32'h2, 1'b0, 10);
        total++; if (errs !== 4'b0100) $display("FAIL wrap_skip_errs: got %b want 0100", errs); else passed++;
        total++; if (err_cnt !== 16'd1) $display("FAIL wrap_err_cnt: got %0d want 1", err_cnt); else passed++;
    endtask

    task automatic test_period();
        do_reset();
        txn(32'd100, 1'b0, 10);
        txn(32'd101, 1'b0, 6);
        total++; if (errs !== {2'b00, PER_EN, 1'b0}) $display("FAIL period_6: got %b want %b", errs, {2'b00, PER_EN, 1'b0}); else passed++;
        txn(32'd102, 1'b0, 13);
        total++; if (errs !== 4'b0) $display("FAIL period_13: got %b want 0000", errs); else passed++;
        txn(32'd103, 1'b0, 14);
        total++; if (errs !== {2'b00, PER_EN, 1'b0}) $display("FAIL period_14: got %b want %b", errs, {2'b00, PER_EN, 1'b0}); else passed++;
        txn(32'd104, 1'b0, 8);
        total++; if (errs !== 4'b0) $display("FAIL period_8: got %b want 0000", errs); else passed++;
        total++; if (err_cnt !== 16'(2 * PER_EN)) $display("FAIL period_err_cnt: got %0d want %0d", err_cnt, 2 * PER_EN); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        txn(32'd1, 1'b0, 10);
        repeat (8) @(negedge clk);
        @(negedge clk);
        count_in = 32'd2; parity_in = ^count_in; valid_in = 1'b1;
        @(negedge clk);
        total++; if (errs !== 4'b0) $display("FAIL b2b_first_errs: got %b want 0000", errs); else passed++;
        count_in = 32'd3; parity_in = ^count_in;
        @(negedge clk);
        valid_in = 1'b0;
        total++; if (errs !== {2'b00, PER_EN, 1'b0}) $display("FAIL b2b_second_errs: got %b want %b", errs, {2'b00, PER_EN, 1'b0}); else passed++;
        total++; if (txn_cnt !== 32'd3) $display("FAIL b2b_txn_cnt: got %0d want 3", txn_cnt); else passed++;
        total++; if (last_count !== 32'd3) $display("FAIL b2b_last_count: got %0d want 3", last_count); else passed++;
    endtask

    task automatic test_window();
        do_reset();
        txn(32'd19, 1'b0, 10);
        txn(32'd20, 1'b0, 10);
        pulse_rst_req();
        total++; if (in_window !== 1'b1) $display("FAIL win_open: got %b want 1", in_window); else passed++;
        txn(32'd20, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b00001) $display("FAIL win_hold1: got %b want 00001", {errs, in_window}); else passed++;
        txn(32'd20, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b00001) $display("FAIL win_hold2: got %b want 00001", {errs, in_window}); else passed++;
        txn(32'd1, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b00000) $display("FAIL win_one: got %b want 00000", {errs, in_window}); else passed++;
        txn(32'd2, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b00000) $display("FAIL win_two: got %b want 00000", {errs, in_window}); else passed++;
        total++; if (err_cnt !== 16'd0) $display("FAIL win_err_cnt: got %0d want 0", err_cnt); else passed++;

        do_reset();
        txn(32'd19, 1'b0, 10);
        txn(32'd20, 1'b0, 10);
        pulse_rst_req();
        txn(32'd20, 1'b0, 10);
        txn(32'd21, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b00010) $display("FAIL win_bad: got %b want 00010", {errs, in_window}); else passed++;
        total++; if (last_count !== 32'd21) $display("FAIL win_bad_last: got %0d want 21", last_count); else passed++;
        total++; if (err_cnt !== 16'd1) $display("FAIL win_bad_err_cnt: got %0d want 1", err_cnt); else passed++;
    endtask

    task automatic test_expiry_async();
        do_reset();
        txn(32'd19, 1'b0, 10);
        txn(32'd20, 1'b0, 10);
        pulse_rst_req();
        repeat (46) @(negedge clk);
        total++; if (in_window !== 1'b0) $display("FAIL exp_closed: got %b want 0", in_window); else passed++;
        txn(32'd20, 1'b0, 2);
        total++; if (errs !== {2'b00, PER_EN, 1'b1}) $display("FAIL exp_txn: got %b want %b", errs, {2'b00, PER_EN, 1'b1}); else passed++;
        total++; if (err_cnt !== 16'(1 + PER_EN)) $display("FAIL exp_err_cnt: got %0d want %0d", err_cnt, 1 + PER_EN); else passed++;
        txn(32'd21, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b00000) $display("FAIL exp_track: got %b want 00000", {errs, in_window}); else passed++;

        pulse_rst_req();
        repeat (3) @(negedge clk);
        total++; if (in_window !== 1'b1) $display("FAIL async_open: got %b want 1", in_window); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({txn_cnt, last_count, err_cnt} !== 80'd0) $display("FAIL async_counts: got %h/%h/%h want 0", txn_cnt, last_count, err_cnt); else passed++;
        total++; if ({errs, in_window} !== 5'b0) $display("FAIL async_flags: got %b want 00000", {errs, in_window}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        txn(32'd500, 1'b0, 10);
        total++; if ({errs, in_window} !== 5'b0) $display("FAIL base_after_rst: got %b want 00000", {errs, in_window}); else passed++;
        total++; if (txn_cnt !== 32'd1 || last_count !== 32'd500) $display("FAIL base_counts: got %0d/%0d want 1/500", txn_cnt, last_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_wrap();
        test_period();
        test_back_to_back();
        test_window();
        test_expiry_async();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
